// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external 8-bit adder among NUM_REQ requesters.
// Optional subtract support (two adder passes) under ADDER_ARB_SUB_EN.
module adder_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_in1,
  input  logic [8*NUM_REQ-1:0] req_in2,
`ifdef ADDER_ARB_SUB_EN
  input  logic [NUM_REQ-1:0]   req_sub,
`endif
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [7:0]           resp_data,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [7:0]           add_in1,
  output logic [7:0]           add_in2,
  input  logic [7:0]           add_out
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
`ifdef ADDER_ARB_SUB_EN
    , ISSUE2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic [7:0]        res_q, res_d;
  logic              sub_q, sub_d;

  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_id;
  logic [7:0]        sel_a;
  logic [7:0]        sel_b;
  logic              sel_sub;
  logic              own_ack;

  // Lowest index at or above rr_q wins; otherwise lowest below it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (j < int'(rr_q))) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(j);
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (j >= int'(rr_q))) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(j);
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    own_ack = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt_id == ID_W'(j)) begin
        sel_a = req_in1[8*j +: 8];
        sel_b = req_in2[8*j +: 8];
`ifdef ADDER_ARB_SUB_EN
        sel_sub = req_sub[j];
`endif
      end
      if (id_q == ID_W'(j)) own_ack = resp_ready[j];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    sub_d      = sub_q;
    req_ready  = '0;
    resp_valid = '0;
    add_in1    = '0;
    add_in2    = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld && !reset) begin
          for (int j = 0; j < NUM_REQ; j++)
            if (gnt_id == ID_W'(j)) req_ready[j] = 1'b1;
          id_d    = gnt_id;
          a_d     = sel_a;
          b_d     = sel_b;
          sub_d   = sel_sub;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        add_in1 = a_q;
        add_in2 = sub_q ? ~b_q : b_q;
        res_d   = add_out;
`ifdef ADDER_ARB_SUB_EN
        state_d = sub_q ? ISSUE2 : RESP;
`else
        state_d = RESP;
`endif
      end
`ifdef ADDER_ARB_SUB_EN
      ISSUE2: begin
        add_in1 = res_q;
        add_in2 = 8'h01;
        res_d   = add_out;
        state_d = RESP;
      end
`endif
      RESP: begin
        for (int j = 0; j < NUM_REQ; j++)
          if (id_q == ID_W'(j)) resp_valid[j] = 1'b1;
        if (own_ack) begin
          if (int'(id_q) == NUM_REQ - 1) rr_d = '0;
          else rr_d = id_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_data = res_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomised bench for adder_arbiter against a transaction-level model.
// Subtract cases run when ADDER_ARB_SUB_EN is defined.
module tb_adder_arbiter;
  localparam int N = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_in1;
  logic [8*N-1:0] req_in2;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [7:0]     resp_data;
  logic [N-1:0]   resp_ready;
  logic [7:0]     add_in1;
  logic [7:0]     add_in2;
  logic [7:0]     add_out;
`ifdef ADDER_ARB_SUB_EN
  logic [N-1:0]   req_sub;
`endif

  int total = 0;
  int bad   = 0;
  int exp_ptr = 0;
  logic [7:0] op_a [N];
  logic [7:0] op_b [N];

  always #5 clock = ~clock;

  assign add_out = add_in1 + add_in2;

  adder_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
`ifdef ADDER_ARB_SUB_EN
    .req_sub    (req_sub),
`endif
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .add_in1    (add_in1),
    .add_in2    (add_in2),
    .add_out    (add_out)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int winner(logic [N-1:0] mask);
    for (int k = 0; k < N; k++)
      if (mask[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
    return -1;
  endfunction

  task automatic check_zero(string tag);
    @(negedge clock);
    check({tag, "_rdy"}, req_ready, 0);
    check({tag, "_rv"}, resp_valid, 0);
    check({tag, "_rd"}, resp_data, 0);
    check({tag, "_a1"}, add_in1, 0);
    check({tag, "_a2"}, add_in2, 0);
  endtask

  task automatic reset_mid(string tag);
    reset = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    step();
    check_zero(tag);
    step();
    reset = 1'b0;
    exp_ptr = 0;
    @(negedge clock);
    check({tag, "_norsp"}, resp_valid, 0);
    step();
  endtask

  // rst_at: 0 none, 1 reset during ISSUE, 2 reset during RESP
  task automatic do_op(input logic [N-1:0] mask, input logic [N-1:0] sub,
                       input int hold, input int rst_at);
    int g;
    logic is_sub;
    logic [7:0] exp;
    logic [7:0] nb;
    for (int i = 0; i < N; i++) begin
      req_in1[8*i +: 8] = op_a[i];
      req_in2[8*i +: 8] = op_b[i];
    end
    req_valid = mask;
`ifdef ADDER_ARB_SUB_EN
    req_sub = sub;
`endif
    g = winner(mask);
    is_sub = 1'b0;
`ifdef ADDER_ARB_SUB_EN
    is_sub = sub[g];
`endif
    nb = ~op_b[g];
    exp = is_sub ? op_a[g] - op_b[g] : op_a[g] + op_b[g];
    @(negedge clock);
    check("grant", req_ready, 32'(1) << g);
    check("idle_a1", add_in1, 0);
    step();
    req_valid = mask & ~(N'(1) << g);
    if (rst_at == 1) begin
      reset_mid("rst_issue");
      return;
    end
    @(negedge clock);
    check("iss_rdy", req_ready, 0);
    check("iss_a1", add_in1, op_a[g]);
    check("iss_a2", add_in2, is_sub ? nb : op_b[g]);
    check("iss_rv", resp_valid, 0);
    step();
    if (is_sub) begin
      @(negedge clock);
      check("iss2_a1", add_in1, op_a[g] + nb);
      check("iss2_a2", add_in2, 8'h01);
      check("iss2_rv", resp_valid, 0);
      step();
    end
    if (rst_at == 2) begin
      reset_mid("rst_resp");
      return;
    end
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) resp_ready = N'(1) << g;
      else resp_ready = N'($urandom) & ~(N'(1) << g);
      @(negedge clock);
      check("rsp_rv", resp_valid, 32'(1) << g);
      check("rsp_data", resp_data, exp);
      check("rsp_rdy", req_ready, 0);
      step();
    end
    resp_ready = '0;
    req_valid = '0;
    exp_ptr = (g + 1) % N;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_in1 = '0;
    req_in2 = '0;
    resp_ready = '0;
`ifdef ADDER_ARB_SUB_EN
    req_sub = '0;
`endif
    step();
    check_zero("reset");
    step();
    reset = 1'b0;
    @(negedge clock);
    check("idle_none", req_ready, 0);
    step();

    op_a[0] = 8'h12; op_b[0] = 8'h34;
    do_op(2'b01, 2'b00, 0, 0);
    op_a[0] = 8'hF0; op_b[0] = 8'h20;
    do_op(2'b01, 2'b00, 0, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = 8'($urandom);
        op_b[i] = 8'($urandom);
      end
      do_op(2'b11, 2'b00, 0, 0);
    end
    do_op(2'b11, 2'b00, 5, 0);

    do_op(2'b11, 2'b00, 0, 1);
    do_op(2'b10, 2'b00, 0, 0);
    do_op(2'b11, 2'b00, 1, 2);
    do_op(2'b11, 2'b00, 0, 0);

`ifdef ADDER_ARB_SUB_EN
    op_a[0] = 8'h05; op_b[0] = 8'h07;
    op_a[1] = 8'h05; op_b[1] = 8'h07;
    do_op(2'b01, 2'b01, 0, 0);
    do_op(2'b10, 2'b00, 0, 0);
`endif

    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = 8'($urandom);
        op_b[i] = 8'($urandom);
      end
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clock);
        check("idle_gap", req_ready, 0);
        step();
      end
      do_op(N'($urandom_range(1, 3)), N'($urandom), $urandom_range(0, 3), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one combinational 8-bit adder instance among NUM_REQ requesters, e.g. the PC incrementer, the branch-target calculator and the ALU pre-adder.
- Requesters use a valid/ready handshake; grants are round-robin.
- Operands are latched, the adder is driven for one cycle, and the registered result is returned on a response handshake to the granted requester only.
- The block owns the adder's input pins; the adder's output feeds back into this block.

Parameters:
NUM_REQ, 2, number of requesters, legal 2..4
ID_W, 2, width of internal grant index, must satisfy 2^ID_W >= NUM_REQ

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
req_valid  input  NUM_REQ  per-requester request strobe
req_in1  input  8*NUM_REQ  operand A, requester i at bits [8i+7:8i]
req_in2  input  8*NUM_REQ  operand B, same packing
req_ready  output  NUM_REQ  one-hot accept, at most one bit high
resp_valid  output  NUM_REQ  one-hot result valid for the owning requester
resp_data  output  8  registered sum, shared bus
resp_ready  input  NUM_REQ  per-requester result acknowledge
add_in1  output  8  to shared adder input 1
add_in2  output  8  to shared adder input 2
add_out  input  8  from shared adder output

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_data=0, add_in1=0, add_in2=0, latched operands/id=0.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[grant]=1 combinationally, only while req_valid[grant]=1; all other bits 0.
  - On req_valid[g] & req_ready[g]: latch req_in1/req_in2 slice g and g, then go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE:
  - add_in1/add_in2 = latched operands.
  - resp_data <= add_out, go to RESP.
  - add_in1/add_in2 are 0 in all other states, so the adder is idle.
- RESP:
  - resp_valid[g]=1, resp_data held stable.
  - Stay until resp_ready[g]=1; on the handshake: resp_valid=0, rr_ptr <= (g+1) mod NUM_REQ, go to IDLE.
  - resp_ready of non-owners is ignored.
- Arithmetic:
  - 8-bit modulo-256 sum; carry discarded.
  - resp_data = (in1+in2) mod 256.
- Latency and throughput:
  - Accept in cycle N → resp_valid high in cycle N+2.
  - Minimum 3 cycles per operation (IDLE, ISSUE, RESP).
  - No new request is accepted outside IDLE; req_ready=0 in ISSUE and RESP.
- Boundary conditions:
  - Simultaneous requests: rr_ptr priority; the winner's successor has top priority next time.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - A requester dropping req_valid before acceptance loses nothing; no grant is latched.
  - Requester indices >= NUM_REQ never granted.
  - Reset asserted in any state aborts the transaction: response dropped, all outputs to reset values on the next edge.
  - Reset has priority over every handshake in the same cycle.

Optional Feature:
- ADDER_ARB_SUB_EN defined:
  - Adds input port req_sub (NUM_REQ bits), latched with the operands.
  - Adds state ISSUE2 between ISSUE and RESP, entered only when the latched sub=1.
  - ISSUE drives add_in1=in1, add_in2=~in2 and captures the partial sum.
  - ISSUE2 drives add_in1=partial, add_in2=8'h01 and captures the final value.
  - Result: resp_data=(in1-in2) mod 256, latency N+3.
  - sub=0 follows the base path unchanged.
- ADDER_ARB_SUB_EN undefined: no req_sub port, no ISSUE2 state; all operations are addition.

Test Plan:
- Reset, then req_valid=2'b01, in1=8'h12, in2=8'h34 → req_ready=01 same cycle; add_in1/add_in2=12/34 at N+1; resp_valid=01, resp_data=8'h46 at N+2; held until resp_ready[0].
- Overflow: in1=8'hF0, in2=8'h20 → resp_data=8'h10.
- Contention with both requesters holding valid, all ready = 1:
  - first grant 0, second grant 1, third grant 0 (alternation).
  - Exactly one req_ready bit high per IDLE cycle.
- Back-pressure:
  - resp_ready low 5 cycles → resp_valid/resp_data stable.
  - req_ready=0 throughout; new request accepted only after the ack.
  - resp_ready[1]=1 while owner is 0 → no effect.
- Reset mid-op: assert reset in ISSUE and again in RESP → next cycle all outputs 0, rr_ptr=0, the pending response never appears.
- ADDER_ARB_SUB_EN: sub=1, in1=8'h05, in2=8'h07 → resp_data=8'hFE at N+3; sub=0, same operands → 8'h0C at N+2.
